// File: rtl/count_sched.sv
// Two-requester round-robin scheduler sharing one W-bit run counter.
// Every output is a flop updated from the next-state logic below.
module count_sched #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         res,
   input  logic [1:0]   req,
   input  logic [W-1:0] len0,
   input  logic [W-1:0] len1,
   output logic [1:0]   gnt,
   output logic [1:0]   done,
   output logic         busy,
   output logic [W-1:0] cnt_out
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};
   localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};

   state_e       state_q, state_d;
   logic [1:0]   gnt_q, gnt_d;
   logic [1:0]   done_q, done_d;
   logic         busy_q, busy_d;
   logic [W-1:0] cnt_q, cnt_d;
   logic [W-1:0] target_q, target_d;
   logic         last_q, last_d;
   logic         win_s;
   logic         owner_req_s;
   logic [W-1:0] final_cnt_s;

   // Round-robin winner: a tie goes to whoever was not served last
   always_comb begin
      win_s = 1'b0;
      if (req == 2'b11) begin
         win_s = ~last_q;
      end else if (req[1]) begin
         win_s = 1'b1;
      end else begin
         win_s = 1'b0;
      end
   end

   assign owner_req_s = gnt_q[1] ? req[1] : req[0];
   // A latched target of 0 wraps to all-ones, giving a full 2^W-cycle run
   assign final_cnt_s = target_q - CNT_ONE;

   // Next-state and next-output computation
   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      done_d   = 2'b00;
      cnt_d    = cnt_q;
      target_d = target_q;
      last_d   = last_q;
      case (state_q)
         IDLE: begin
            if (req != 2'b00) begin
               state_d  = RUN;
               gnt_d    = win_s ? 2'b10 : 2'b01;
               cnt_d    = CNT_ZERO;
               target_d = win_s ? len1 : len0;
               last_d   = win_s;
            end else begin
               gnt_d = 2'b00;
            end
         end
         RUN: begin
            if (!owner_req_s) begin
               state_d = IDLE;
               gnt_d   = 2'b00;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == final_cnt_s) begin
               state_d = DONE;
               gnt_d   = 2'b00;
               done_d  = gnt_q;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         DONE: begin
            state_d = IDLE;
            gnt_d   = 2'b00;
         end
         default: begin
            state_d = IDLE;
            gnt_d   = 2'b00;
            cnt_d   = CNT_ZERO;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and output registers; reset leaves requester 0 first in line
   always_ff @(posedge clk) begin
      if (res) begin
         state_q  <= IDLE;
         gnt_q    <= 2'b00;
         done_q   <= 2'b00;
         busy_q   <= 1'b0;
         cnt_q    <= CNT_ZERO;
         target_q <= CNT_ZERO;
         last_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
         target_q <= target_d;
         last_q   <= last_d;
      end
   end

   assign gnt     = gnt_q;
   assign done    = done_q;
   assign busy    = busy_q;
   assign cnt_out = cnt_q;

endmodule

// File: tb/tb_count_sched.sv
// Self-checking bench for count_sched: directed scenarios plus randomized
// traffic, all compared against a cycle-level reference model.
module tb_count_sched;
   localparam int W = 3;

   logic         clk = 1'b0;
   logic         res;
   logic [1:0]   req;
   logic [W-1:0] len0, len1;
   logic [1:0]   gnt, done;
   logic         busy;
   logic [W-1:0] cnt_out;
   wire  [7:0]   obs = {gnt, done, busy, cnt_out};

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: phase 0 idle, 1 running, 2 done; m_left = granted cycles still owed
   int m_phase = 0;
   int m_owner = 0;
   int m_left  = 0;
   int m_cnt   = 0;
   int m_last  = 1;

   always #5 clk = ~clk;

   count_sched #(.W(W)) dut (
      .clk(clk), .res(res), .req(req), .len0(len0), .len1(len1),
      .gnt(gnt), .done(done), .busy(busy), .cnt_out(cnt_out)
   );

   function automatic logic [7:0] exp_vec();
      logic [1:0] oh;
      logic [7:0] v;
      oh = (m_owner == 1) ? 2'b10 : 2'b01;
      v[7:6] = (m_phase == 1) ? oh : 2'b00;
      v[5:4] = (m_phase == 2) ? oh : 2'b00;
      v[3]   = (m_phase != 0);
      v[2:0] = m_cnt[2:0];
      return v;
   endfunction

   task automatic tick();
      int w;
      @(posedge clk);
      if (res) begin
         m_phase = 0; m_cnt = 0; m_last = 1; m_owner = 0;
      end else begin
         case (m_phase)
            0: if (req != 2'b00) begin
                  if (req == 2'b11) w = 1 - m_last;
                  else w = req[1] ? 1 : 0;
                  m_owner = w;
                  m_left  = w ? int'(len1) : int'(len0);
                  if (m_left == 0) m_left = 1 << W;
                  m_cnt   = 0;
                  m_last  = w;
                  m_phase = 1;
               end
            1: if (!req[m_owner]) begin
                  m_phase = 0; m_cnt = 0;
               end else if (m_left == 1) begin
                  m_phase = 2;
               end else begin
                  m_left = m_left - 1;
                  m_cnt  = (m_cnt + 1) % (1 << W);
               end
            default: m_phase = 0;
         endcase
      end
      #1;
   endtask

   task automatic apply_reset();
      res = 1'b1;
      tick();
      res = 1'b0;
   endtask

   task automatic test_reset();
      res = 1'b1; req = 2'b11; len0 = 3'd2; len1 = 3'd3;
      tick(); tick();
      n_tests++;
      if (obs !== 8'b0) begin
         n_fail++; $display("FAIL reset_outputs got %b want %b", obs, 8'b0);
      end
      n_tests++;
      if (obs !== exp_vec()) begin
         n_fail++; $display("FAIL reset_model got %b want %b", obs, exp_vec());
      end
      req = 2'b00;
      res = 1'b0;
      tick();
   endtask

   task automatic test_single();
      logic [7:0] tbl [5];
      tbl = '{8'b01_00_1_000, 8'b01_00_1_001, 8'b01_00_1_010,
              8'b00_01_1_010, 8'b00_00_0_010};
      apply_reset();
      req = 2'b01; len0 = 3'd3; len1 = 3'($urandom_range(0, 7));
      for (int i = 0; i < 5; i++) begin
         tick();
         if (done != 2'b00) req = 2'b00;
         n_tests++;
         if (obs !== tbl[i] || obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL single cyc %0d got %b want %b model %b", i, obs, tbl[i], exp_vec());
         end
      end
   endtask

   task automatic test_round_robin();
      logic [1:0] order [$];
      int gaps [$];
      logic [1:0] prev;
      int idle_run;
      res = 1'b1; req = 2'b11; len0 = 3'd2; len1 = 3'd1;
      tick();
      res = 1'b0;
      prev = 2'b00; idle_run = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         n_tests++;
         if (obs !== exp_vec()) begin
            n_fail++; $display("FAIL rr cyc %0d got %b want %b", i, obs, exp_vec());
         end
         if (gnt != 2'b00 && prev == 2'b00) begin
            order.push_back(gnt);
            gaps.push_back(idle_run);
         end
         idle_run = (gnt == 2'b00) ? idle_run + 1 : 0;
         prev = gnt;
      end
      n_tests++;
      if (order.size() < 4 || order[0] !== 2'b01 || order[1] !== 2'b10 ||
          order[2] !== 2'b01 || order[3] !== 2'b10) begin
         n_fail++; $display("FAIL rr_order got %p want 01,10,01,10", order);
      end
      for (int k = 1; k < 4 && k < gaps.size(); k++) begin
         n_tests++;
         if (gaps[k] != 2) begin
            n_fail++; $display("FAIL rr_gap run %0d got %0d want 2", k, gaps[k]);
         end
      end
      req = 2'b00;
      tick(); tick(); tick();
   endtask

   task automatic test_len_zero();
      apply_reset();
      req = 2'b10; len1 = 3'd0; len0 = 3'd5;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done != 2'b00) req = 2'b00;
         n_tests++;
         if (obs !== exp_vec()) begin
            n_fail++; $display("FAIL len0wrap cyc %0d got %b want %b", i, obs, exp_vec());
         end
         if (i < 8) begin
            n_tests++;
            if (gnt !== 2'b10 || cnt_out !== 3'(i)) begin
               n_fail++; $display("FAIL len0wrap_run cyc %0d gnt %b cnt %0d want 10 %0d", i, gnt, cnt_out, i);
            end
         end else if (i == 8) begin
            n_tests++;
            if (done !== 2'b10 || cnt_out !== 3'd7 || busy !== 1'b1) begin
               n_fail++; $display("FAIL len0wrap_done done %b cnt %0d busy %b want 10 7 1", done, cnt_out, busy);
            end
         end
      end
   endtask

   task automatic test_abort();
      apply_reset();
      req = 2'b01; len0 = 3'd5; len1 = 3'd2;
      tick(); tick();
      req = 2'b00;
      tick();
      n_tests++;
      if (obs !== 8'b0 || obs !== exp_vec()) begin
         n_fail++; $display("FAIL abort got %b want %b", obs, 8'b0);
      end
      req = 2'b11;
      tick();
      n_tests++;
      if (gnt !== 2'b10 || obs !== exp_vec()) begin
         n_fail++; $display("FAIL abort_next got %b want gnt 10 model %b", obs, exp_vec());
      end
      req = 2'b00;
      tick(); tick();
   endtask

   task automatic test_reset_mid();
      apply_reset();
      req = 2'b11; len0 = 3'd6; len1 = 3'd6;
      tick(); tick(); tick();
      res = 1'b1;
      tick();
      n_tests++;
      if (obs !== 8'b0 || obs !== exp_vec()) begin
         n_fail++; $display("FAIL reset_mid got %b want %b", obs, 8'b0);
      end
      res = 1'b0;
      tick();
      n_tests++;
      if (gnt !== 2'b01 || obs !== exp_vec()) begin
         n_fail++; $display("FAIL reset_mid_regrant got %b want gnt 01 model %b", obs, exp_vec());
      end
      req = 2'b00;
      tick(); tick();
   endtask

   task automatic test_len_change();
      int gcount;
      apply_reset();
      req = 2'b01; len0 = 3'd4;
      tick();
      len0 = 3'd1;
      gcount = (gnt == 2'b01) ? 1 : 0;
      for (int i = 0; i < 7; i++) begin
         tick();
         if (done != 2'b00) req = 2'b00;
         if (gnt == 2'b01) gcount++;
         n_tests++;
         if (obs !== exp_vec()) begin
            n_fail++; $display("FAIL lenchg cyc %0d got %b want %b", i, obs, exp_vec());
         end
      end
      n_tests++;
      if (gcount != 4) begin
         n_fail++; $display("FAIL lenchg_cycles got %0d want 4", gcount);
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int i = 0; i < 600; i++) begin
         res = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 7) == 0) req[0] = ~req[0];
         if ($urandom_range(0, 7) == 0) req[1] = ~req[1];
         len0 = 3'($urandom_range(0, 7));
         len1 = 3'($urandom_range(0, 7));
         tick();
         n_tests++;
         if (obs !== exp_vec() || gnt === 2'b11 || done === 2'b11) begin
            n_fail++; $display("FAIL random cyc %0d got %b want %b", i, obs, exp_vec());
         end
      end
      res = 1'b0; req = 2'b00;
   endtask

   initial begin
      res = 1'b1; req = 2'b00; len0 = 3'd0; len1 = 3'd0;
      test_reset();
      test_single();
      test_round_robin();
      test_len_zero();
      test_abort();
      test_reset_mid();
      test_len_change();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/count_sched.md
COUNT_SCHED -- requirements
Module: count_sched

Interface
REQ-001 Parameter: W, default 3, width of the shared counter and of each requested length.
REQ-002 Port: clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 Port: res  input  1  reset, synchronous, active-high; sampled only on posedge clk.
REQ-004 Port: req  input  2  level request per requester (bit i = requester i); held until done[i] or withdrawn.
REQ-005 Port: len0  input  W  requested run length for requester 0, in cycles; value 0 means 2^W cycles.
REQ-006 Port: len1  input  W  requested run length for requester 1, same encoding as len0.
REQ-007 Port: gnt  output  2  one-hot grant; bit i high for every cycle requester i owns the counter.
REQ-008 Port: done  output  2  one-cycle pulse on bit i when requester i's run completes normally.
REQ-009 Port: busy  output  1  high whenever state is not IDLE.
REQ-010 Port: cnt_out  output  W  current value of the shared counter.

Function
REQ-011 FSM states SHALL be exactly IDLE, RUN and DONE; each output is a registered function of the state.
REQ-012 IDLE, no req bit set -> stay IDLE; gnt=00, done=00, cnt_out holds its last value.
REQ-013 IDLE, any req bit set at cycle t -> at t+1: state RUN, gnt one-hot for the winner, cnt_out=0, target latched from the winner's len at t.
REQ-014 Arbitration SHALL be round-robin: single requester wins outright; both requesting -> the requester not served last wins.
REQ-015 The last-served pointer SHALL update on entry to RUN.
REQ-016 Each RUN cycle: cnt_out increments by 1 modulo 2^W; gnt stays constant.
REQ-017 RUN with cnt_out == target-1 (W-bit compare; target 0 -> cnt_out all-ones) -> next cycle state DONE.
REQ-018 Consequence of REQ-016/017: gnt is high for exactly L cycles (L = len, or 2^W when len=0), with cnt_out stepping 0..L-1.
REQ-019 DONE (one cycle): done[i]=1 for the served requester, gnt=00, busy=1, cnt_out holds the final value L-1 (mod 2^W); next state IDLE unconditionally.
REQ-020 Abort: RUN with req[i] of the granted requester low -> next cycle IDLE, gnt=00, no done pulse, cnt_out=0; the pointer still records i as served.
REQ-021 len0/len1 changes during RUN SHALL be ignored; only the latched target is used.
REQ-022 A request for the other requester during RUN SHALL wait and be arbitrated in the next IDLE cycle.
REQ-023 A req still high in the DONE cycle is a new request, arbitrated in IDLE under REQ-014.
REQ-024 Back-to-back service SHALL cost exactly 2 non-granted cycles (DONE, IDLE) between runs.
REQ-025 gnt SHALL never have both bits set; done SHALL never have both bits set.

Reset
REQ-026 res high at a posedge SHALL force, on the next cycle: state IDLE, gnt=00, done=00, busy=0, cnt_out=0, pointer set so requester 0 wins the first tie.
REQ-027 res SHALL override every state, including mid-RUN and DONE; no done pulse is emitted for an interrupted run.
REQ-028 res has priority over req; requests present while res is high are not granted until the first cycle after res falls.

Verification
REQ-029 W=3, reset, then req=01 with len0=3 -> gnt=01 for 3 cycles (cnt_out 0,1,2), then done=01 for 1 cycle, then busy=0.
REQ-030 req=11 held continuously from reset, len0=2, len1=1 -> grant order 0,1,0,1, with 2 non-granted cycles between each run.
REQ-031 req=10 with len1=0 -> gnt=10 for 8 cycles, cnt_out 0..7, done=10, cnt_out holds 7 during DONE.
REQ-032 req0 dropped on the 2nd RUN cycle of a len0=5 run -> next cycle IDLE, gnt=00, no done pulse; a subsequent req=11 grants requester 1 first.
REQ-033 res asserted on the 3rd RUN cycle -> next cycle all outputs 0, state IDLE; with req=11 held, requester 0 is granted 1 cycle after res falls.
REQ-034 len0 changed from 4 to 1 after grant -> run still lasts 4 cycles.
